// File: rtl/loop_index_sequencer.sv
// Two-level row-major loop controller: walks rows x cols, emitting (row, col, addr)
// beats on a valid/ready stream with a start/done handshake toward the layer controller.
module loop_index_sequencer #(
  parameter int Bits     = 8,
  parameter int AddrBits = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [Bits-1:0]     rows_i,
  input  logic [Bits-1:0]     cols_i,
  input  logic                abort_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [Bits-1:0]     row_o,
  output logic [Bits-1:0]     col_o,
  output logic [AddrBits-1:0] addr_o,
  output logic                last_o,
  output logic                busy_o,
  output logic                done_o
);

  if (AddrBits < 2*Bits) begin : g_addr_chk
    $error("loop_index_sequencer: AddrBits must be >= 2*Bits");
  end

  localparam logic [Bits-1:0]     One     = Bits'(1);
  localparam logic [AddrBits-1:0] AddrOne = AddrBits'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [Bits-1:0]     rows_q, cols_q, row_q, col_q;
  logic [AddrBits-1:0] addr_q;
  logic                last_q;

  logic            start_ok, aborting, xfer, fin, col_wrap;
  logic [Bits-1:0] row_nx, col_nx;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    aborting = 1'b0;
    xfer     = 1'b0;
    fin      = 1'b0;
    valid_o  = 1'b0;
    done_o   = 1'b0;
    busy_o   = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (rows_i != '0 && cols_i != '0) begin
            start_ok = 1'b1;
            state_d  = RUN;
          end else begin
            state_d  = DONE;
          end
        end
      end
      RUN: begin
        valid_o = 1'b1;
        // abort wins over a coincident handshake; that beat is not consumed
        if (abort_i) begin
          aborting = 1'b1;
          state_d  = IDLE;
        end else if (ready_i) begin
          xfer = 1'b1;
          if (last_q) begin
            fin     = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign col_wrap = (col_q == cols_q - One);
  assign col_nx   = col_wrap ? '0 : col_q + One;
  assign row_nx   = col_wrap ? row_q + One : row_q;

  // last is precomputed for the beat about to be presented so it is a clean register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rows_q <= '0;
      cols_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
      last_q <= 1'b0;
    end else if (start_ok) begin
      rows_q <= rows_i;
      cols_q <= cols_i;
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
      last_q <= (rows_i == One) && (cols_i == One);
    end else if (aborting) begin
      last_q <= 1'b0;
    end else if (xfer) begin
      if (fin) begin
        last_q <= 1'b0;
      end else begin
        row_q  <= row_nx;
        col_q  <= col_nx;
        addr_q <= addr_q + AddrOne;
        last_q <= (row_nx == rows_q - One) && (col_nx == cols_q - One);
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign addr_o = addr_q;
  assign last_o = last_q;

endmodule

// File: tb/tb_loop_index_sequencer.sv
// Scoreboard bench for loop_index_sequencer: expected beats are generated from nested
// row/col loops when a sequence is started and popped as the DUT hands beats over.
module tb_loop_index_sequencer;
  localparam int Bits     = 8;
  localparam int AddrBits = 16;

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic                start_i = 1'b0;
  logic [Bits-1:0]     rows_i = '0;
  logic [Bits-1:0]     cols_i = '0;
  logic                abort_i = 1'b0;
  logic                ready_i = 1'b0;
  logic                valid_o, last_o, busy_o, done_o;
  logic [Bits-1:0]     row_o, col_o;
  logic [AddrBits-1:0] addr_o;

  loop_index_sequencer #(.Bits(Bits), .AddrBits(AddrBits)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .rows_i(rows_i), .cols_i(cols_i),
    .abort_i(abort_i), .valid_o(valid_o), .ready_i(ready_i), .row_o(row_o),
    .col_o(col_o), .addr_o(addr_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {int r; int c; int a; bit l;} beat_t;
  beat_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_seq(input int nr, input int nc);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        exp_q.push_back('{r, c, r*nc + c, (r == nr-1) && (c == nc-1)});
  endtask

  task automatic do_start(input int nr, input int nc);
    start_i = 1'b1; rows_i = Bits'(nr); cols_i = Bits'(nc);
    tick();
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b1; rows_i = 8'd3; cols_i = 8'd3;
    tick(); tick();
    start_i = 1'b0;
    n_cmp++;
    if ({valid_o, row_o, col_o, addr_o, last_o, busy_o, done_o} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b r=%0d c=%0d a=%0d l=%b b=%b d=%b want all 0",
               valid_o, row_o, col_o, addr_o, last_o, busy_o, done_o);
    end
    rst_i = 1'b0;
    tick();
    n_cmp++;
    if ({valid_o, busy_o, done_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_idle: got v=%b b=%b d=%b want 000", valid_o, busy_o, done_o);
    end
  endtask

  task automatic test_basic();
    beat_t e; int nb = 0; int nd = 0; int dc = -1; int lc = -1;
    exp_q.delete(); push_seq(2, 3);
    ready_i = 1'b1;
    do_start(2, 3);
    for (int cyc = 0; cyc < 20; cyc++) begin
      n_cmp++;
      if (busy_o !== 1'(nd == 0)) begin
        n_err++; $display("FAIL basic_busy: cyc %0d got %b want %b", cyc, busy_o, nd == 0);
      end
      if (done_o) begin nd++; dc = cyc; end
      if (valid_o && ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL basic_beat: extra beat r=%0d c=%0d a=%0d", row_o, col_o, addr_o);
        end else begin
          e = exp_q.pop_front();
          if ({row_o, col_o, addr_o, last_o} !== {Bits'(e.r), Bits'(e.c), AddrBits'(e.a), e.l}) begin
            n_err++;
            $display("FAIL basic_beat: got (%0d,%0d,%0d,l=%b) want (%0d,%0d,%0d,l=%b)",
                     row_o, col_o, addr_o, last_o, e.r, e.c, e.a, e.l);
          end
        end
        n_cmp++;
        if (nb != cyc) begin
          n_err++; $display("FAIL basic_contig: beat %0d at cyc %0d", nb, cyc);
        end
        nb++; lc = cyc;
      end
      tick();
    end
    n_cmp++;
    if (nb != 6) begin n_err++; $display("FAIL basic_count: got %0d beats want 6", nb); end
    n_cmp++;
    if (nd != 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", nd); end
    n_cmp++;
    if (lc != 5 || dc != 6) begin
      n_err++; $display("FAIL basic_timing: last xfer cyc %0d done cyc %0d want 5/6", lc, dc);
    end
    ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    beat_t e; int nb = 0; int nd = 0; int dc = -1; int lc = -1;
    logic pv = 1'b0; logic px = 1'b0;
    logic [Bits-1:0] pr = '0; logic [Bits-1:0] pc = '0; logic [AddrBits-1:0] pa = '0; logic pl = 1'b0;
    exp_q.delete(); push_seq(2, 3);
    do_start(2, 3);
    for (int cyc = 0; cyc < 30; cyc++) begin
      ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (valid_o && pv && !px) begin
        n_cmp++;
        if ({row_o, col_o, addr_o, last_o} !== {pr, pc, pa, pl}) begin
          n_err++;
          $display("FAIL bp_hold: got (%0d,%0d,%0d,%b) want (%0d,%0d,%0d,%b)",
                   row_o, col_o, addr_o, last_o, pr, pc, pa, pl);
        end
      end
      if (done_o) begin nd++; dc = cyc; end
      if (valid_o && ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL bp_beat: extra beat a=%0d", addr_o);
        end else begin
          e = exp_q.pop_front();
          if ({row_o, col_o, addr_o, last_o} !== {Bits'(e.r), Bits'(e.c), AddrBits'(e.a), e.l}) begin
            n_err++;
            $display("FAIL bp_beat: got (%0d,%0d,%0d,l=%b) want (%0d,%0d,%0d,l=%b)",
                     row_o, col_o, addr_o, last_o, e.r, e.c, e.a, e.l);
          end
        end
        nb++; lc = cyc;
      end
      pv = valid_o; px = valid_o && ready_i;
      pr = row_o; pc = col_o; pa = addr_o; pl = last_o;
      tick();
    end
    n_cmp++;
    if (nb != 6) begin n_err++; $display("FAIL bp_count: got %0d beats want 6", nb); end
    n_cmp++;
    if (nd != 1 || dc != lc + 1) begin
      n_err++; $display("FAIL bp_done: count %0d at cyc %0d, last xfer cyc %0d", nd, dc, lc);
    end
    ready_i = 1'b0;
  endtask

  task automatic test_zero_dim();
    ready_i = 1'b1;
    do_start(0, 5);
    for (int cyc = 0; cyc < 5; cyc++) begin
      n_cmp++;
      if ({valid_o, done_o, busy_o} !== {1'b0, 1'(cyc == 0), 1'(cyc == 0)}) begin
        n_err++;
        $display("FAIL zero_dim: cyc %0d got v=%b d=%b b=%b want 0 %b %b",
                 cyc, valid_o, done_o, busy_o, cyc == 0, cyc == 0);
      end
      tick();
    end
    ready_i = 1'b0;
  endtask

  task automatic test_single();
    beat_t e; int nb = 0; int nd = 0; int dc = -1;
    exp_q.delete(); push_seq(1, 1);
    ready_i = 1'b0;
    do_start(1, 1);
    start_i = 1'b1; rows_i = 8'd9; cols_i = 8'd9;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc == 2) start_i = 1'b0;
      ready_i = (cyc >= 2);
      n_cmp++;
      if (valid_o !== 1'(cyc <= 2)) begin
        n_err++; $display("FAIL single_valid: cyc %0d got %b want %b", cyc, valid_o, cyc <= 2);
      end
      if (done_o) begin nd++; dc = cyc; end
      if (valid_o && ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL single_beat: extra beat a=%0d", addr_o);
        end else begin
          e = exp_q.pop_front();
          if ({row_o, col_o, addr_o, last_o} !== {Bits'(e.r), Bits'(e.c), AddrBits'(e.a), e.l}) begin
            n_err++;
            $display("FAIL single_beat: got (%0d,%0d,%0d,l=%b) want (%0d,%0d,%0d,l=%b)",
                     row_o, col_o, addr_o, last_o, e.r, e.c, e.a, e.l);
          end
        end
        nb++;
      end
      tick();
    end
    n_cmp++;
    if (nb != 1 || nd != 1 || dc != 3) begin
      n_err++; $display("FAIL single_summary: beats %0d dones %0d done cyc %0d want 1/1/3", nb, nd, dc);
    end
    ready_i = 1'b0;
  endtask

  task automatic test_abort();
    beat_t e; int nd = 0; int ab = -1; int nb = 0;
    exp_q.delete(); push_seq(4, 4);
    ready_i = 1'b1;
    do_start(4, 4);
    for (int cyc = 0; cyc < 15; cyc++) begin
      abort_i = 1'b0;
      if (done_o) nd++;
      if (ab >= 0 && cyc == ab + 1) begin
        n_cmp++;
        if ({valid_o, busy_o, done_o} !== 3'b000) begin
          n_err++; $display("FAIL abort_idle: got v=%b b=%b d=%b want 000", valid_o, busy_o, done_o);
        end
      end
      if (valid_o && ready_i) begin
        n_cmp++;
        e = exp_q.pop_front();
        if ({row_o, col_o, addr_o} !== {Bits'(e.r), Bits'(e.c), AddrBits'(e.a)}) begin
          n_err++;
          $display("FAIL abort_beat: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                   row_o, col_o, addr_o, e.r, e.c, e.a);
        end
        if (addr_o == 16'd6) begin abort_i = 1'b1; ab = cyc; end
      end
      tick();
    end
    abort_i = 1'b0;
    n_cmp++;
    if (ab != 6 || nd != 0) begin
      n_err++; $display("FAIL abort_summary: abort cyc %0d dones %0d want 6/0", ab, nd);
    end
    exp_q.delete(); push_seq(1, 2);
    nd = 0;
    do_start(1, 2);
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (done_o) nd++;
      if (valid_o && ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL restart_beat: extra beat a=%0d", addr_o);
        end else begin
          e = exp_q.pop_front();
          if ({row_o, col_o, addr_o, last_o} !== {Bits'(e.r), Bits'(e.c), AddrBits'(e.a), e.l}) begin
            n_err++;
            $display("FAIL restart_beat: got (%0d,%0d,%0d,l=%b) want (%0d,%0d,%0d,l=%b)",
                     row_o, col_o, addr_o, last_o, e.r, e.c, e.a, e.l);
          end
        end
        nb++;
      end
      tick();
    end
    n_cmp++;
    if (nb != 2 || nd != 1) begin
      n_err++; $display("FAIL restart_summary: beats %0d dones %0d want 2/1", nb, nd);
    end
    ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    int rc = -1;
    exp_q.delete();
    ready_i = 1'b1;
    do_start(3, 3);
    for (int cyc = 0; cyc < 12 && rc < 0; cyc++) begin
      if (valid_o && addr_o == 16'd3) begin rst_i = 1'b1; rc = cyc; end
      tick();
    end
    rst_i = 1'b0;
    n_cmp++;
    if (rc < 0 || {valid_o, row_o, col_o, addr_o, last_o, busy_o, done_o} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: rc=%0d got v=%b r=%0d c=%0d a=%0d l=%b b=%b d=%b want all 0",
               rc, valid_o, row_o, col_o, addr_o, last_o, busy_o, done_o);
    end
    ready_i = 1'b0;
    tick();
  endtask

  task automatic test_big();
    beat_t e; int nb = 0; int nd = 0;
    int lr = -1; int lcl = -1; int la = -1;
    exp_q.delete(); push_seq(255, 255);
    ready_i = 1'b1;
    do_start(255, 255);
    for (int cyc = 0; cyc < 65100 && nd == 0; cyc++) begin
      if (done_o) nd++;
      if (valid_o && ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL big_beat: extra beat a=%0d", addr_o);
        end else begin
          e = exp_q.pop_front();
          if ({row_o, col_o, addr_o, last_o} !== {Bits'(e.r), Bits'(e.c), AddrBits'(e.a), e.l}) begin
            n_err++;
            $display("FAIL big_beat: got (%0d,%0d,%0d,l=%b) want (%0d,%0d,%0d,l=%b)",
                     row_o, col_o, addr_o, last_o, e.r, e.c, e.a, e.l);
          end
        end
        if (last_o) begin lr = row_o; lcl = col_o; la = addr_o; end
        nb++;
      end
      tick();
    end
    n_cmp++;
    if (nb != 65025 || nd != 1) begin
      n_err++; $display("FAIL big_summary: beats %0d dones %0d want 65025/1", nb, nd);
    end
    n_cmp++;
    if (lr != 254 || lcl != 254 || la != 65024) begin
      n_err++; $display("FAIL big_last: got (%0d,%0d,%0d) want (254,254,65024)", lr, lcl, la);
    end
    ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_dim();
    test_single();
    test_abort();
    test_reset_mid();
    test_big();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
